// File: rtl/apb_requester_arbiter_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_requester_arbiter_pkg;

   localparam int NUM_REQ = 2;
   localparam int GRANT_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; search starts just after the last winner.
module rr_arbiter
   import apb_requester_arbiter_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req,
   input  logic               update_en,
   output logic               gnt_any,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [GRANT_W-1:0] gnt_idx
);

   logic [GRANT_W-1:0] last_grant_q;
   logic [GRANT_W-1:0] last_grant_d;

   always_comb begin
      logic [GRANT_W-1:0] cand;
      gnt_any    = 1'b0;
      gnt_onehot = '0;
      gnt_idx    = '0;
      cand       = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = GRANT_W'((int'(last_grant_q) + i) % NUM_REQ);
         if (!gnt_any && req[cand]) begin
            gnt_any          = 1'b1;
            gnt_idx          = cand;
            gnt_onehot[cand] = 1'b1;
         end
      end
   end

   always_comb begin
      last_grant_d = last_grant_q;
      if (update_en && gnt_any) begin
         last_grant_d = gnt_idx;
      end
   end

   // Resetting to the highest index makes requester 0 win the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant_q <= GRANT_W'(NUM_REQ - 1);
      end else begin
         last_grant_q <= last_grant_d;
      end
   end

endmodule

// File: rtl/apb_requester_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS transfer, registered response.
module apb_requester_arbiter
   import apb_requester_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                                PCLK,
   input  logic                                PRESETn,
   input  logic [NUM_REQ-1:0]                  req_valid,
   output logic [NUM_REQ-1:0]                  req_ready,
   input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ-1:0]                  req_write,
   input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]                  rsp_valid,
   output logic [DATA_WIDTH-1:0]               rsp_rdata,
   output logic                                rsp_err,
   output logic                                PSEL,
   output logic                                PENABLE,
   output logic                                PWRITE,
   output logic [ADDR_WIDTH-1:0]               PADDR,
   output logic [DATA_WIDTH-1:0]               PWDATA,
   input  logic [DATA_WIDTH-1:0]               PRDATA,
   input  logic                                PREADY,
   input  logic                                PSLVERR
);

   state_e                 state_q, state_d;
   logic                   psel_q, psel_d;
   logic                   penable_q, penable_d;
   logic                   pwrite_q, pwrite_d;
   logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]  pwdata_q, pwdata_d;
   logic [GRANT_W-1:0]     grant_q, grant_d;
   logic [NUM_REQ-1:0]     rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
   logic                   rsp_err_q, rsp_err_d;

   logic                   gnt_any;
   logic [NUM_REQ-1:0]     gnt_onehot;
   logic [GRANT_W-1:0]     gnt_idx;
   logic                   in_idle;

   assign in_idle = (state_q == IDLE);

   rr_arbiter u_rr_arbiter (
      .clk        (PCLK),
      .rst_n      (PRESETn),
      .req        (req_valid),
      .update_en  (in_idle),
      .gnt_any    (gnt_any),
      .gnt_onehot (gnt_onehot),
      .gnt_idx    (gnt_idx)
   );

   // The only combinational output: accept strobe for the winner while idle.
   assign req_ready = (in_idle && gnt_any) ? gnt_onehot : '0;

   always_comb begin
      state_d     = state_q;
      psel_d      = psel_q;
      penable_d   = penable_q;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      grant_d     = grant_q;
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d   = SETUP;
               psel_d    = 1'b1;
               penable_d = 1'b0;
               pwrite_d  = req_write[gnt_idx];
               paddr_d   = req_addr[gnt_idx];
               pwdata_d  = req_wdata[gnt_idx];
               grant_d   = gnt_idx;
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            // PSLVERR and PRDATA are only meaningful in the PREADY cycle.
            if (PREADY) begin
               state_d              = IDLE;
               psel_d               = 1'b0;
               penable_d            = 1'b0;
               rsp_valid_d[grant_q] = 1'b1;
               rsp_rdata_d          = pwrite_q ? '0 : PRDATA;
               rsp_err_d            = PSLVERR;
            end
         end
         default: begin
            state_d   = IDLE;
            psel_d    = 1'b0;
            penable_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         grant_q     <= '0;
         rsp_valid_q <= '0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         psel_q      <= psel_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         grant_q     <= grant_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign PSEL      = psel_q;
   assign PENABLE   = penable_q;
   assign PWRITE    = pwrite_q;
   assign PADDR     = paddr_q;
   assign PWDATA    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester_arbiter.sv
// Bench for apb_requester_arbiter: directed scenarios plus randomized traffic against a timing model.
module tb_apb_requester_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic                PCLK = 1'b0;
   logic                PRESETn = 1'b0;
   logic [1:0]          req_valid = '0;
   logic [1:0]          req_ready;
   logic [1:0][AW-1:0]  req_addr = '0;
   logic [1:0]          req_write = '0;
   logic [1:0][DW-1:0]  req_wdata = '0;
   logic [1:0]          rsp_valid;
   logic [DW-1:0]       rsp_rdata;
   logic                rsp_err;
   logic                PSEL, PENABLE, PWRITE;
   logic [AW-1:0]       PADDR;
   logic [DW-1:0]       PWDATA;
   logic [DW-1:0]       PRDATA = '0;
   logic                PREADY = 1'b0;
   logic                PSLVERR = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 PCLK = ~PCLK;

   apb_requester_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   task automatic clear_inputs();
      req_valid = '0; req_addr = '0; req_write = '0; req_wdata = '0;
      PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESETn = 1'b0;
      clear_inputs();
      repeat (2) @(negedge PCLK);
      PRESETn = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge PCLK);
      PRESETn = 1'b0;
      clear_inputs();
      #1;
      n_cmp++; if ({PSEL, PENABLE, PWRITE} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl: got %b want 000", {PSEL, PENABLE, PWRITE}); end
      n_cmp++; if ({PADDR, PWDATA} !== '0) begin n_err++; $display("FAIL reset_addr_data: got %h want 0", {PADDR, PWDATA}); end
      n_cmp++; if ({rsp_valid, rsp_err, req_ready} !== 5'b0) begin n_err++; $display("FAIL reset_rsp: got %b want 0", {rsp_valid, rsp_err, req_ready}); end
      n_cmp++; if (rsp_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
      @(negedge PCLK);
      PRESETn = 1'b1;
      @(negedge PCLK); #1;
      n_cmp++; if ({PSEL, PENABLE, rsp_valid} !== 4'b0) begin n_err++; $display("FAIL reset_idle_after: got %b want 0", {PSEL, PENABLE, rsp_valid}); end
   endtask

   task automatic test_single_read();
      @(negedge PCLK);
      req_valid = 2'b01; req_addr[0] = 32'h10; req_write[0] = 1'b0;
      PREADY = 1'b1; PRDATA = 32'hCAFE_0001; PSLVERR = 1'b0;
      #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rd_ready: got %b want 01", req_ready); end
      @(negedge PCLK); req_valid = 2'b00; #1;
      n_cmp++; if ({PSEL, PENABLE, PWRITE, PADDR} !== {3'b100, 32'h10}) begin n_err++; $display("FAIL rd_setup: got %b/%h want 100/10", {PSEL, PENABLE, PWRITE}, PADDR); end
      @(negedge PCLK); #1;
      n_cmp++; if ({PSEL, PENABLE} !== 2'b11) begin n_err++; $display("FAIL rd_access: got %b want 11", {PSEL, PENABLE}); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL rd_early_rsp: got %b want 00", rsp_valid); end
      @(negedge PCLK); PREADY = 1'b0; #1;
      n_cmp++; if ({rsp_valid, rsp_err, PSEL, PENABLE} !== 5'b01000) begin n_err++; $display("FAIL rd_rsp: got %b want 01000", {rsp_valid, rsp_err, PSEL, PENABLE}); end
      n_cmp++; if (rsp_rdata !== 32'hCAFE_0001) begin n_err++; $display("FAIL rd_rdata: got %h want cafe0001", rsp_rdata); end
   endtask

   task automatic test_wait_states();
      @(negedge PCLK);
      req_valid = 2'b10; req_addr[1] = 32'h20; req_write[1] = 1'b1; req_wdata[1] = 32'h1234_5678;
      PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
      #1;
      n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL ws_ready: got %b want 10", req_ready); end
      @(negedge PCLK);
      req_valid = 2'b01; req_addr[0] = 32'h30; req_write[0] = 1'b0;
      #1;
      n_cmp++; if ({PSEL, PENABLE, PWRITE, req_ready} !== 5'b10100) begin n_err++; $display("FAIL ws_setup: got %b want 10100", {PSEL, PENABLE, PWRITE, req_ready}); end
      for (int k = 0; k < 4; k++) begin
         @(negedge PCLK);
         PREADY = (k == 3);
         #1;
         n_cmp++; if ({PSEL, PENABLE, req_ready, rsp_valid} !== 6'b110000) begin n_err++; $display("FAIL ws_access%0d: got %b want 110000", k, {PSEL, PENABLE, req_ready, rsp_valid}); end
         n_cmp++; if ({PADDR, PWDATA} !== {32'h20, 32'h1234_5678}) begin n_err++; $display("FAIL ws_stable%0d: got %h/%h want 20/12345678", k, PADDR, PWDATA); end
      end
      @(negedge PCLK); PRDATA = 32'h55; #1;
      n_cmp++; if ({rsp_valid, PENABLE} !== 3'b100) begin n_err++; $display("FAIL ws_rsp: got %b want 100", {rsp_valid, PENABLE}); end
      n_cmp++; if (rsp_rdata !== '0) begin n_err++; $display("FAIL ws_wr_rdata: got %h want 0", rsp_rdata); end
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL ws_b2b_ready: got %b want 01", req_ready); end
      @(negedge PCLK); req_valid = 2'b00; #1;
      @(negedge PCLK); #1;
      @(negedge PCLK); PREADY = 1'b0; #1;
      n_cmp++; if ({rsp_valid, rsp_rdata} !== {2'b01, 32'h55}) begin n_err++; $display("FAIL ws_b2b_rsp: got %b/%h want 01/55", rsp_valid, rsp_rdata); end
   endtask

   task automatic test_tie_fairness();
      logic [1:0] exp_ready, exp_rsp;
      int w;
      do_reset();
      for (int k = 0; k <= 12; k++) begin
         @(negedge PCLK);
         req_valid = (k < 12) ? 2'b11 : 2'b00;
         req_addr[0] = 32'h100; req_addr[1] = 32'h101; req_write = 2'b00;
         PREADY = 1'b1; PRDATA = 32'(k);
         #1;
         w = (k / 3) % 2;
         exp_ready = (k < 12 && k % 3 == 0) ? (2'b01 << w) : 2'b00;
         exp_rsp = (k > 0 && k % 3 == 0) ? (2'b01 << (((k / 3) - 1) % 2)) : 2'b00;
         n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL tie_ready%0d: got %b want %b", k, req_ready, exp_ready); end
         n_cmp++; if (rsp_valid !== exp_rsp) begin n_err++; $display("FAIL tie_rsp%0d: got %b want %b", k, rsp_valid, exp_rsp); end
         if (k % 3 == 1) begin
            n_cmp++; if (PADDR !== 32'h100 + 32'(w)) begin n_err++; $display("FAIL tie_paddr%0d: got %h want %h", k, PADDR, 32'h100 + 32'(w)); end
         end
      end
   endtask

   task automatic test_error();
      @(negedge PCLK);
      req_valid = 2'b01; req_addr[0] = 32'h40; req_write[0] = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
      @(negedge PCLK); req_valid = 2'b00;
      @(negedge PCLK); PSLVERR = 1'b1;
      @(negedge PCLK); PREADY = 1'b1; PRDATA = 32'hE1;
      @(negedge PCLK);
      PREADY = 1'b0; PSLVERR = 1'b0;
      req_valid = 2'b01; req_addr[0] = 32'h44;
      #1;
      n_cmp++; if ({rsp_valid, rsp_err} !== 3'b011) begin n_err++; $display("FAIL err_rsp: got %b want 011", {rsp_valid, rsp_err}); end
      n_cmp++; if (rsp_rdata !== 32'hE1) begin n_err++; $display("FAIL err_rdata: got %h want e1", rsp_rdata); end
      @(negedge PCLK); req_valid = 2'b00;
      @(negedge PCLK); PSLVERR = 1'b1; #1;
      n_cmp++; if ({rsp_valid, rsp_err} !== 3'b001) begin n_err++; $display("FAIL err_hold: got %b want 001", {rsp_valid, rsp_err}); end
      @(negedge PCLK); PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hE2;
      @(negedge PCLK); PREADY = 1'b0; #1;
      n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {3'b010, 32'hE2}) begin n_err++; $display("FAIL err_ignored: got %b/%h want 010/e2", {rsp_valid, rsp_err}, rsp_rdata); end
   endtask

   task automatic test_reset_mid();
      @(negedge PCLK);
      req_valid = 2'b10; req_addr[1] = 32'h50; req_write[1] = 1'b0; PREADY = 1'b0;
      @(negedge PCLK); req_valid = 2'b00;
      @(negedge PCLK); #1;
      n_cmp++; if ({PSEL, PENABLE} !== 2'b11) begin n_err++; $display("FAIL rst_mid_access: got %b want 11", {PSEL, PENABLE}); end
      @(negedge PCLK); PRESETn = 1'b0; #1;
      n_cmp++; if ({PSEL, PENABLE, rsp_valid} !== 4'b0) begin n_err++; $display("FAIL rst_mid_abort: got %b want 0", {PSEL, PENABLE, rsp_valid}); end
      PREADY = 1'b1;
      @(negedge PCLK); PRESETn = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge PCLK); #1;
         n_cmp++; if ({PSEL, rsp_valid} !== 3'b0) begin n_err++; $display("FAIL rst_mid_norsp%0d: got %b want 0", k, {PSEL, rsp_valid}); end
      end
      @(negedge PCLK); req_valid = 2'b11; #1;
      n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_mid_tie: got %b want 01", req_ready); end
      @(negedge PCLK); req_valid = 2'b00;
      @(negedge PCLK);
      @(negedge PCLK); #1;
      n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL rst_mid_retry: got %b want 01", rsp_valid); end
   endtask

   // Randomized traffic: each accepted transfer occupies cycles t+1 (SETUP) .. t+2+waits (ACCESS),
   // with the response in cycle t+3+waits; a tie goes to the requester that did not win last.
   task automatic test_random();
      logic [1:0]          hold, exp_ready, exp_rsp;
      logic [1:0][AW-1:0]  h_addr;
      logic [1:0]          h_write;
      logic [1:0][DW-1:0]  h_wdata;
      logic [AW-1:0]       e_addr;
      logic [DW-1:0]       e_wdata, p_rdata, e_rdata;
      logic                e_write, e_err, exp_psel, exp_pen;
      bit                  busy, rsp_cyc, idle;
      int                  t_acc, waits, g, last_g, w, acc_cnt;
      do_reset();
      hold = '0; h_addr = '0; h_write = '0; h_wdata = '0;
      busy = 0; last_g = 1; acc_cnt = 0; t_acc = 0; waits = 0; g = 0;
      e_addr = '0; e_wdata = '0; p_rdata = '0; e_rdata = '0; e_write = 0; e_err = 0;
      for (int c = 0; c < 400; c++) begin
         @(negedge PCLK);
         for (int r = 0; r < 2; r++) begin
            if (!hold[r[0]] && $urandom_range(0, 2) != 0) begin
               hold[r[0]] = 1'b1; h_addr[r[0]] = $urandom; h_wdata[r[0]] = $urandom;
               h_write[r[0]] = 1'($urandom_range(0, 1));
            end
         end
         req_valid = hold; req_addr = h_addr; req_write = h_write; req_wdata = h_wdata;
         if (busy && c >= t_acc + 2 && c < t_acc + 2 + waits) begin
            PREADY = 1'b0; PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
         end else if (busy && c == t_acc + 2 + waits) begin
            PREADY = 1'b1; PSLVERR = e_err; PRDATA = p_rdata;
         end else begin
            PREADY = 1'($urandom_range(0, 1)); PSLVERR = 1'($urandom_range(0, 1)); PRDATA = $urandom;
         end
         #1;
         rsp_cyc = busy && (c == t_acc + 3 + waits);
         idle = !busy || rsp_cyc;
         exp_psel = busy && c >= t_acc + 1 && c <= t_acc + 2 + waits;
         exp_pen = busy && c >= t_acc + 2 && c <= t_acc + 2 + waits;
         exp_rsp = rsp_cyc ? (2'b01 << g) : 2'b00;
         w = -1;
         if (idle && hold != 2'b00) w = (hold == 2'b11) ? 1 - last_g : (hold[0] ? 0 : 1);
         exp_ready = (w >= 0) ? (2'b01 << w) : 2'b00;
         n_cmp++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready c%0d: got %b want %b", c, req_ready, exp_ready); end
         n_cmp++; if ({PSEL, PENABLE, rsp_valid} !== {exp_psel, exp_pen, exp_rsp}) begin n_err++; $display("FAIL rnd_ctrl c%0d: got %b want %b", c, {PSEL, PENABLE, rsp_valid}, {exp_psel, exp_pen, exp_rsp}); end
         if (exp_psel) begin
            n_cmp++; if ({PADDR, PWRITE, PWDATA} !== {e_addr, e_write, e_wdata}) begin n_err++; $display("FAIL rnd_apb c%0d: got %h/%b/%h want %h/%b/%h", c, PADDR, PWRITE, PWDATA, e_addr, e_write, e_wdata); end
         end
         if (rsp_cyc) begin
            n_cmp++; if ({rsp_rdata, rsp_err} !== {e_rdata, e_err}) begin n_err++; $display("FAIL rnd_rsp c%0d: got %h/%b want %h/%b", c, rsp_rdata, rsp_err, e_rdata, e_err); end
            busy = 0;
         end
         if (w >= 0) begin
            busy = 1; t_acc = c; waits = $urandom_range(0, 3); g = w; last_g = w;
            e_addr = h_addr[w[0]]; e_write = h_write[w[0]]; e_wdata = h_wdata[w[0]];
            p_rdata = $urandom; e_err = 1'($urandom_range(0, 1));
            e_rdata = e_write ? '0 : p_rdata;
            hold[w[0]] = 1'b0; acc_cnt++;
         end
      end
      n_cmp++; if (acc_cnt < 40) begin n_err++; $display("FAIL rnd_progress: got %0d transfers want >= 40", acc_cnt); end
      @(negedge PCLK); clear_inputs();
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_wait_states();
      test_tie_fairness();
      test_error();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
